// File: rtl/mmio_pkg.sv
// Shared constants and decode helpers for the MMIO router and its sub-blocks.
package mmio_pkg;

  localparam int          DEV_AW_DEFAULT = 8;
  localparam logic [31:0] MISS_RDATA     = 32'h0;

  // Device-index width; a single device still gets one index bit.
  function automatic int idx_w(input int n_dev);
    return (n_dev <= 2) ? 1 : $clog2(n_dev);
  endfunction

endpackage

// File: rtl/mmio_shadow_reg.sv
// 32-bit shadow register with byte-lane write merge and synchronous reset.
module mmio_shadow_reg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_q
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mask[b]) q_d[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) q_q <= '0;
    else       q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/mmio_router.sv
// Two-stage MMIO decoder: stage 1 drives device strobes, stage 2 returns read data.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int          N_DEV  = 4,
  parameter int          DEV_AW = DEV_AW_DEFAULT,
  parameter logic [29:0] BASE   = 30'h00001,
  parameter logic [7:0]  SHADOW = 8'b0000_0001
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [29:0]          i_mmio_addr,
  input  logic [31:0]          i_mmio_data,
  input  logic [3:0]           i_mmio_mask,
  input  logic                 i_mmio_wren,
  input  logic                 i_mmio_rden,
  output logic [31:0]          o_mmio_data,
  output logic                 o_mmio_rvalid,
  output logic                 o_mmio_err,
  output logic [7:0]           o_err_cnt,
  output logic [DEV_AW-1:0]    o_dev_addr,
  output logic [31:0]          o_dev_wdata,
  output logic [3:0]           o_dev_mask,
  output logic [N_DEV-1:0]     o_dev_wren,
  output logic [N_DEV-1:0]     o_dev_rden,
  input  logic [32*N_DEV-1:0]  i_dev_rdata
);

  localparam int               IDX_W   = idx_w(N_DEV);
  localparam int               UP_W    = 30 - DEV_AW - IDX_W;
  localparam logic [IDX_W:0]   N_DEV_C = (IDX_W + 1)'(N_DEV);

  // Request decode (stage 0)
  logic [IDX_W-1:0] req_idx;
  logic             req_hit, req_off0, req_wr, req_rd;

  assign req_idx  = i_mmio_addr[DEV_AW +: IDX_W];
  assign req_hit  = (i_mmio_addr[29 -: UP_W] == BASE[UP_W-1:0]) && ({1'b0, req_idx} < N_DEV_C);
  assign req_off0 = (i_mmio_addr[DEV_AW-1:0] == '0);
  // An empty byte mask makes the write a complete no-op; a write also suppresses a simultaneous read.
  assign req_wr   = i_mmio_wren && (i_mmio_mask != 4'b0000);
  assign req_rd   = i_mmio_rden && !i_mmio_wren;

  logic [DEV_AW-1:0] dev_addr_q, dev_addr_d;
  logic [31:0]       dev_wdata_q, dev_wdata_d;
  logic [3:0]        dev_mask_q, dev_mask_d;
  logic [N_DEV-1:0]  dev_wren_q, dev_wren_d;
  logic [N_DEV-1:0]  dev_rden_q, dev_rden_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              rd_q, rd_d;
  logic              rd_miss_q, rd_miss_d;
  logic              rd_shadow_q, rd_shadow_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       mdata_q, mdata_d;
  logic [31:0]       shadow_val [N_DEV];
  logic [31:0]       rsp_dev, rsp_shadow;

  for (genvar d = 0; d < N_DEV; d++) begin : g_dev
    if (SHADOW[d]) begin : g_sh
      mmio_shadow_reg u_shadow (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (dev_wren_d[d] && req_off0),
        .i_wdata (i_mmio_data),
        .i_mask  (i_mmio_mask),
        .o_q     (shadow_val[d])
      );
    end else begin : g_nosh
      assign shadow_val[d] = '0;
    end
  end

  always_comb begin
    dev_addr_d  = i_mmio_addr[DEV_AW-1:0];
    dev_wdata_d = i_mmio_data;
    dev_mask_d  = i_mmio_mask;
    dev_wren_d  = '0;
    dev_rden_d  = '0;
    for (int d = 0; d < N_DEV; d++) begin
      dev_wren_d[d] = req_wr && req_hit && (req_idx == IDX_W'(d));
      dev_rden_d[d] = req_rd && req_hit && (req_idx == IDX_W'(d));
    end
    err_d     = (req_wr || req_rd) && !req_hit;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    rd_d        = req_rd;
    rd_miss_d   = !req_hit;
    rd_shadow_d = req_hit && req_off0 && SHADOW[req_idx];
    rd_idx_d    = req_idx;

    // Stage 2 samples the device bus during the rden cycle.
    rsp_dev    = '0;
    rsp_shadow = '0;
    for (int d = 0; d < N_DEV; d++) begin
      if (rd_idx_q == IDX_W'(d)) begin
        rsp_dev    = i_dev_rdata[32*d +: 32];
        rsp_shadow = shadow_val[d];
      end
    end
    rvalid_d = rd_q;
    mdata_d  = mdata_q;
    if (rd_q) mdata_d = rd_miss_q ? MISS_RDATA : (rd_shadow_q ? rsp_shadow : rsp_dev);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      dev_mask_q  <= '0;
      dev_wren_q  <= '0;
      dev_rden_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      rd_q        <= 1'b0;
      rd_miss_q   <= 1'b0;
      rd_shadow_q <= 1'b0;
      rd_idx_q    <= '0;
      rvalid_q    <= 1'b0;
      mdata_q     <= '0;
    end else begin
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      dev_mask_q  <= dev_mask_d;
      dev_wren_q  <= dev_wren_d;
      dev_rden_q  <= dev_rden_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      rd_q        <= rd_d;
      rd_miss_q   <= rd_miss_d;
      rd_shadow_q <= rd_shadow_d;
      rd_idx_q    <= rd_idx_d;
      rvalid_q    <= rvalid_d;
      mdata_q     <= mdata_d;
    end
  end

  assign o_dev_addr    = dev_addr_q;
  assign o_dev_wdata   = dev_wdata_q;
  assign o_dev_mask    = dev_mask_q;
  assign o_dev_wren    = dev_wren_q;
  assign o_dev_rden    = dev_rden_q;
  assign o_mmio_err    = err_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_mmio_rvalid = rvalid_q;
  assign o_mmio_data   = mdata_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed plus randomized bench for mmio_router against a transaction-level reference model.
module tb_mmio_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [29:0]  mmio_addr;
  logic [31:0]  mmio_data;
  logic [3:0]   mmio_mask;
  logic         mmio_wren, mmio_rden;
  logic [31:0]  mmio_rdata;
  logic         mmio_rvalid, mmio_err;
  logic [7:0]   err_cnt;
  logic [7:0]   dev_addr;
  logic [31:0]  dev_wdata;
  logic [3:0]   dev_mask, dev_wren, dev_rden;
  logic [127:0] dev_rdata;

  always #5 clk = ~clk;

  mmio_router dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mmio_addr   (mmio_addr),
    .i_mmio_data   (mmio_data),
    .i_mmio_mask   (mmio_mask),
    .i_mmio_wren   (mmio_wren),
    .i_mmio_rden   (mmio_rden),
    .o_mmio_data   (mmio_rdata),
    .o_mmio_rvalid (mmio_rvalid),
    .o_mmio_err    (mmio_err),
    .o_err_cnt     (err_cnt),
    .o_dev_addr    (dev_addr),
    .o_dev_wdata   (dev_wdata),
    .o_dev_mask    (dev_mask),
    .o_dev_wren    (dev_wren),
    .o_dev_rden    (dev_rden),
    .i_dev_rdata   (dev_rdata)
  );

  typedef struct {
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        wren;
    logic        rden;
  } req_t;

  int checks = 0;
  int errors = 0;
  int steps_done = 0;

  // Reference model state: one shadowed device (0), error counter, last read data.
  logic [31:0] m_shadow0;
  int          m_cnt;
  logic [31:0] m_last;
  req_t        prev_req;

  // Expected stage-1 outputs of the previous request.
  logic [3:0]  e_wren, e_rden, e_mask;
  logic        e_err;
  logic [7:0]  e_cnt, e_addr;
  logic [31:0] e_wdata;

  // Scoreboard of expected {rvalid, data} per cycle.
  logic [32:0] exp_q[$];

  function automatic req_t mk(input logic r, input logic [29:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic w, input logic rd);
    req_t t;
    t.rst = r; t.addr = a; t.data = d; t.mask = m; t.wren = w; t.rden = rd;
    return t;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic req_t rand_req();
    logic [19:0] up;
    logic [7:0]  off;
    logic [1:0]  idx;
    up  = ($urandom_range(0, 9) < 8) ? 20'h1 : 20'($urandom_range(0, 3));
    idx = 2'($urandom_range(0, 3));
    off = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
    return mk($urandom_range(0, 49) == 0, {up, idx, off}, $urandom,
              4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response of prev_req, decided by what the bus carries during its strobe cycle.
  task automatic resolve(input logic cur_rst, input logic [127:0] rd);
    logic [31:0] d;
    int          idx;
    if (cur_rst) begin
      m_last = 32'h0;
      exp_q.push_back({1'b0, 32'h0});
    end else if (!prev_req.rst && prev_req.rden && !prev_req.wren) begin
      idx = int'(prev_req.addr[9:8]);
      if (prev_req.addr[29:10] != 20'h1) d = 32'h0;
      else if (idx == 0 && prev_req.addr[7:0] == 8'h00) d = m_shadow0;
      else d = rd[32*idx +: 32];
      m_last = d;
      exp_q.push_back({1'b1, d});
    end else begin
      exp_q.push_back({1'b0, m_last});
    end
  endtask

  task automatic model_s1(input req_t r);
    logic hit, wr, rdq;
    int   idx;
    if (r.rst) begin
      e_wren = '0; e_rden = '0; e_err = 1'b0; e_cnt = '0;
      e_addr = '0; e_wdata = '0; e_mask = '0;
      m_cnt = 0; m_shadow0 = 32'h0;
      return;
    end
    hit = (r.addr[29:10] == 20'h1);
    idx = int'(r.addr[9:8]);
    wr  = r.wren && (r.mask != 4'b0000);
    rdq = r.rden && !r.wren;
    e_wren = (wr && hit) ? 4'(1 << idx) : 4'b0;
    e_rden = (rdq && hit) ? 4'(1 << idx) : 4'b0;
    e_err  = (wr || rdq) && !hit;
    if (e_err && m_cnt < 255) m_cnt++;
    e_cnt   = 8'(m_cnt);
    e_addr  = r.addr[7:0];
    e_wdata = r.data;
    e_mask  = r.mask;
    if (wr && hit && idx == 0 && r.addr[7:0] == 8'h00) begin
      for (int b = 0; b < 4; b++)
        if (r.mask[b]) m_shadow0[8*b +: 8] = r.data[8*b +: 8];
    end
  endtask

  task automatic step(input req_t r, input logic [127:0] rd);
    logic [32:0] e2;
    @(posedge clk);
    #1;
    if (steps_done > 0) begin
      chk("dev_wren", 32'(dev_wren), 32'(e_wren));
      chk("dev_rden", 32'(dev_rden), 32'(e_rden));
      chk("mmio_err", 32'(mmio_err), 32'(e_err));
      chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
      chk("dev_addr", 32'(dev_addr), 32'(e_addr));
      chk("dev_wdata", dev_wdata, e_wdata);
      chk("dev_mask", 32'(dev_mask), 32'(e_mask));
      e2 = exp_q.pop_front();
      chk("rvalid", 32'(mmio_rvalid), 32'(e2[32]));
      chk("rdata", mmio_rdata, e2[31:0]);
    end
    resolve(r.rst, rd);
    model_s1(r);
    rst       = r.rst;
    mmio_addr = r.addr;
    mmio_data = r.data;
    mmio_mask = r.mask;
    mmio_wren = r.wren;
    mmio_rden = r.rden;
    dev_rdata = rd;
    prev_req  = r;
    steps_done++;
  endtask

  localparam logic [127:0] RD_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  initial begin
    rst = 1'b1; mmio_addr = '0; mmio_data = '0; mmio_mask = '0;
    mmio_wren = 1'b0; mmio_rden = 1'b0; dev_rdata = '0;
    m_shadow0 = '0; m_cnt = 0; m_last = '0;
    prev_req = mk(1'b1, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Reset with live requests that must be ignored.
    step(mk(1, 30'h400, 32'hFFFF_FFFF, 4'hF, 1, 0), rand128());
    step(mk(1, 30'h500, 32'h0, 4'h0, 0, 1), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());

    // Write to non-shadowed device 1.
    step(mk(0, 30'h500, 32'hDEADBEEF, 4'b0011, 1, 0), rand128());
    // Partial shadow write then read back.
    step(mk(0, 30'h400, 32'h12345678, 4'b0011, 1, 0), rand128());
    step(mk(0, 30'h400, 32'h0, 4'h0, 0, 1), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    chk("shadow_readback_valid", 32'(mmio_rvalid), 32'd1);
    chk("shadow_readback_data", mmio_rdata, 32'h00005678);

    // Unmapped read.
    step(mk(0, 30'h000, 32'h0, 4'h0, 0, 1), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    chk("miss_err_cnt", 32'(err_cnt), 32'd1);

    // Back-to-back reads to devices 1..3.
    step(mk(0, 30'h500, 32'h0, 4'h0, 0, 1), RD_A);
    step(mk(0, 30'h600, 32'h0, 4'h0, 0, 1), RD_A);
    step(mk(0, 30'h700, 32'h0, 4'h0, 0, 1), RD_A);
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), RD_A);
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), RD_A);

    // Simultaneous write+read, zero-mask write, then read back.
    step(mk(0, 30'h400, 32'hCAFEF00D, 4'hF, 1, 1), rand128());
    step(mk(0, 30'h400, 32'h11111111, 4'h0, 1, 0), rand128());
    step(mk(0, 30'h000, 32'h11111111, 4'h0, 1, 0), rand128());
    step(mk(0, 30'h400, 32'h0, 4'h0, 0, 1), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());

    // Reset while a read is in flight.
    step(mk(0, 30'h500, 32'h0, 4'h0, 0, 1), rand128());
    step(mk(1, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());

    for (int i = 0; i < 400; i++) step(rand_req(), rand128());

    // Error counter saturation.
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    for (int i = 0; i < 300; i++) step(mk(0, 30'($urandom_range(0, 1023)), 32'h0, 4'h0, 0, 1), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    step(mk(0, 30'h0, 32'h0, 4'h0, 0, 0), rand128());
    chk("err_cnt_saturated", 32'(err_cnt), 32'h0000_00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
